// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data memory.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise DM wins ties.
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          run
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic          gnt, last_gnt, sel;
  logic [CW-1:0] cnt;
  logic          any_req;

  assign any_req = if_req | dm_req;

  // sel: 0 = IF, 1 = DM
  always_comb begin
    sel = dm_req;
    if (if_req && dm_req) begin
`ifdef ARB_RR_EN
      sel = ~last_gnt;
`else
      sel = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // WAIT spans LAT+1 cycles: the strobe cycle plus LAT cycles of memory latency.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= 1'b0;
      last_gnt  <= 1'b0;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      mem_en <= 1'b0;
      if (state == IDLE && any_req) begin
        gnt      <= sel;
        last_gnt <= sel;
        mem_en   <= 1'b1;
        mem_we   <= sel & dm_we;
        mem_addr <= sel ? dm_addr : if_addr;
        if (sel) mem_wdata <= dm_wdata;
        cnt      <= CW'(LAT);
      end
      if (state == WAIT) begin
        if (cnt == '0) begin
          if (!gnt)         if_rdata <= mem_rdata;
          else if (!mem_we) dm_rdata <= mem_rdata;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

  assign if_ack = (state == DONE) && !gnt;
  assign dm_ack = (state == DONE) &&  gnt;
  assign run    = (!if_req | if_ack) & (!dm_req | dm_ack);

endmodule
